ws2812_multi_frame_seq: RTL and testbench
=========================================

Name: ws2812_multi_frame_seq

Overview:
- Parametrised frame sequencer that replaces the single-strip ship/reset controller in the LED Pong datapath.
- Drives up to NUM_CH WS2812B strips in turn. For each strip it enables the GRB serialiser, then times the >280 us reset/latch gap internally rather than waiting on the serialiser's reset handshake.
- Supports one-shot frames triggered by a debounced button and a free-running auto-refresh mode, plus a clean abort path.
- Sits between the button/switch inputs and the GRB serialiser's channel mux.

Parameters:
- NUM_CH, 4, number of LED strips sequenced per frame (>=1).
- RESET_CYCLES, 28000, clk cycles the line is held low after each strip (280 us at 100 MHz; >=1).
- DEBOUNCE_CYCLES, 1000000, consecutive go-low cycles required before re-arming (>=1).
- FCNT_W, 16, width of the frame counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- go  in  1  start request (button); already synchronous to clk.
- auto_mode  in  1  1 = restart frames continuously without go.
- abort  in  1  synchronous request to stop the current frame.
- bit_done  in  1  serialiser has sent the last data bit of the current strip.
- ship  out  NUM_CH  one-hot; bit ch enables the serialiser for strip ch.
- ch_sel  out  max(1,$clog2(NUM_CH))  index of the active strip.
- latch_low  out  1  serialiser must hold all outputs low (reset code).
- ready  out  1  okay to press go.
- frame_done  out  1  one-cycle pulse when a full frame completes.
- frame_count  out  FCNT_W  completed-frame count; wraps modulo 2^FCNT_W.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - state=IDLE, ch_sel=0, cnt=0, abort_flag=0.
  - ship=0, latch_low=0, frame_done=0, frame_count=0, ready=1.
- States: IDLE, SHIP, LATCH, DBOUNCE. All outputs except frame_done/frame_count decode from state.
  - ready=(IDLE); ship[ch_sel]=(SHIP); latch_low=(LATCH).
- IDLE:
  - go | auto_mode → SHIP next cycle, ch_sel=0.
  - Latency: go seen at edge n, ship[0] high after edge n.
- SHIP:
  - bit_done → LATCH, cnt=0.
  - abort (with or without bit_done) → LATCH, cnt=0, abort_flag=1.
- LATCH:
  - cnt increments each cycle; latch_low is high for exactly RESET_CYCLES cycles.
  - Exit when cnt==RESET_CYCLES-1. At exit:
    - abort_flag=1 → DBOUNCE; clear abort_flag; no frame_done; frame_count unchanged.
    - ch_sel<NUM_CH-1 → SHIP, ch_sel+1.
    - ch_sel==NUM_CH-1 → frame_done=1 for one cycle and frame_count+1. Then auto_mode=1 → SHIP with ch_sel=0; otherwise → DBOUNCE with cnt=0.
  - abort during LATCH sets abort_flag. The gap is never shortened.
- DBOUNCE:
  - go=1 clears cnt; go=0 increments cnt.
  - cnt==DEBOUNCE_CYCLES-1 with go=0 → IDLE.
  - auto_mode is ignored here. Re-entering auto needs IDLE.
- Ignored inputs:
  - bit_done is ignored outside SHIP.
  - abort is ignored in IDLE and DBOUNCE.
  - go is ignored outside IDLE and DBOUNCE.
- Widths and encoding:
  - cnt width = $clog2(max(RESET_CYCLES,DEBOUNCE_CYCLES)+1).
  - ship is all-zero except in SHIP. Never more than one bit set.
- NUM_CH=1: ch_sel is 1 bit, permanently 0.

Decomposition:
- Package ws2812_pkg holds:
  - state enum (IDLE, SHIP, LATCH, DBOUNCE);
  - timing constants T_RESET_100MHZ=28000 and T_DEBOUNCE_100MHZ=1000000.
- One sub-module: ws2812_cycle_timer, a clear/enable up-counter with terminal-count flag. It is shared by LATCH and DBOUNCE.

Test Plan (NUM_CH=3, RESET_CYCLES=8, DEBOUNCE_CYCLES=4, FCNT_W=4):
- One-shot frame:
  - Stimulus: go pulse in IDLE, bit_done 5 cycles after each ship.
  - Response: ship=001,010,100 in order; latch_low high 8 cycles after each strip; frame_done one pulse; frame_count=1; DBOUNCE, then IDLE 4 cycles after go low.
- Debounce:
  - Stimulus: after frame_done, hold go high 10 cycles, toggle low 2/high 1, then low.
  - Response: ready rises exactly 4 cycles after the final go fall.
- Auto mode:
  - Stimulus: auto_mode=1 from reset.
  - Response: frames back-to-back with no IDLE between; ship=001 in the cycle after the third latch ends; 17 frames → frame_count wraps to 1.
- Abort:
  - Stimulus: abort during ship=010, and separately abort coincident with bit_done.
  - Response: LATCH for 8 cycles, then DBOUNCE; no frame_done; frame_count unchanged; ship=100 never asserted.
- Async reset mid-LATCH:
  - Stimulus: reset asserted between clk edges.
  - Response: latch_low=0, ship=0, ready=1 immediately, before the next edge; frame_count=0.
- Spurious inputs:
  - Stimulus: bit_done in IDLE/LATCH, abort in IDLE.
  - Response: no state change, outputs stable.

Source files
------------

// File: rtl/ws2812_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ws2812_pkg                                                   |
// | Description : Shared types and timing constants for the WS2812 multi-strip |
// |               frame sequencer.                                             |
// | Contents    : seq_state_t  - sequencer state encoding                      |
// |               T_RESET_100MHZ, T_DEBOUNCE_100MHZ - default timing at 100MHz |
// |               max_int      - elaboration-time helper                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package ws2812_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIP    = 2'd1,
    LATCH   = 2'd2,
    DBOUNCE = 2'd3
  } seq_state_t;

  // 280 us latch gap and 10 ms button debounce at a 100 MHz clock
  localparam int T_RESET_100MHZ    = 28000;
  localparam int T_DEBOUNCE_100MHZ = 1000000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ws2812_cycle_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ws2812_cycle_timer                                           |
// | Description : Clear/enable up-counter with a terminal-count flag. One      |
// |               instance is time-shared between the latch gap and the        |
// |               button debounce window.                                      |
// | Ports       : clk, reset  - clock, async active-high reset                 |
// |               clear       - synchronous clear (wins over enable)           |
// |               enable      - count up by one                                |
// |               limit       - terminal value to compare against              |
// |               at_limit    - count == limit                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ws2812_cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             at_limit
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign at_limit = (count == limit);

endmodule
`default_nettype wire

// File: rtl/ws2812_multi_frame_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ws2812_multi_frame_seq                                       |
// | Description : Frame sequencer for NUM_CH WS2812B strips. Enables the GRB   |
// |               serialiser for each strip in turn, times the reset/latch gap |
// |               after each strip, and supports one-shot (button) frames,     |
// |               free-running auto refresh and abort.                         |
// | Ports       : clk, reset  - clock, async active-high reset                 |
// |               go          - start request (synchronous button)             |
// |               auto_mode   - restart frames continuously                    |
// |               abort       - stop the current frame after the latch gap     |
// |               bit_done    - serialiser finished the current strip          |
// |               ship        - one-hot serialiser enable per strip            |
// |               ch_sel      - index of the active strip                      |
// |               latch_low   - hold serial lines low (reset code)             |
// |               ready       - idle, go accepted                              |
// |               frame_done  - one-cycle pulse per completed frame            |
// |               frame_count - completed frames, wraps                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ws2812_multi_frame_seq
  import ws2812_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int RESET_CYCLES    = T_RESET_100MHZ,
  parameter int DEBOUNCE_CYCLES = T_DEBOUNCE_100MHZ,
  parameter int FCNT_W          = 16,
  localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic              auto_mode,
  input  logic              abort,
  input  logic              bit_done,
  output logic [NUM_CH-1:0] ship,
  output logic [CH_W-1:0]   ch_sel,
  output logic              latch_low,
  output logic              ready,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_count
);

  localparam int CNT_W = $clog2(max_int(RESET_CYCLES, DEBOUNCE_CYCLES) + 1);
  localparam logic [CNT_W-1:0] RESET_LAST    = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CH_W-1:0]  LAST_CH       = CH_W'(NUM_CH - 1);

  seq_state_t       state, state_next;
  logic             abort_flag;
  logic             timer_clear, timer_en, timer_tc;
  logic [CNT_W-1:0] timer_limit;
  logic             last_ch, abort_pending, latch_exit, frame_end;

  ws2812_cycle_timer #(
    .WIDTH (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (timer_clear),
    .enable   (timer_en),
    .limit    (timer_limit),
    .at_limit (timer_tc)
  );

  assign last_ch = (ch_sel == LAST_CH);
  // An abort arriving on the very last latch cycle still ends the frame.
  assign abort_pending = abort_flag | abort;
  assign latch_exit    = (state == LATCH) && timer_tc;
  assign frame_end     = latch_exit && !abort_pending && last_ch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    timer_limit = RESET_LAST;
    case (state)
      IDLE: begin
        timer_clear = 1'b1;
        if (go || auto_mode) state_next = SHIP;
      end
      SHIP: begin
        timer_clear = 1'b1;
        if (bit_done || abort) state_next = LATCH;
      end
      LATCH: begin
        timer_en = 1'b1;
        if (timer_tc) begin
          timer_clear = 1'b1;
          if (abort_pending)  state_next = DBOUNCE;
          else if (!last_ch)  state_next = SHIP;
          else if (auto_mode) state_next = SHIP;
          else                state_next = DBOUNCE;
        end
      end
      DBOUNCE: begin
        timer_limit = DEBOUNCE_LAST;
        if (go) begin
          timer_clear = 1'b1;
        end else if (timer_tc) begin
          timer_clear = 1'b1;
          state_next  = IDLE;
        end else begin
          timer_en = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_sel      <= '0;
      abort_flag  <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= frame_end;
      if (frame_end) frame_count <= frame_count + 1'b1;

      if (latch_exit) begin
        abort_flag <= 1'b0;
      end else if (abort && (state == SHIP || state == LATCH)) begin
        abort_flag <= 1'b1;
      end

      // ch_sel returns to 0 whenever a frame ends or is abandoned, so the
      // IDLE->SHIP transition always starts from strip 0.
      if (latch_exit) begin
        ch_sel <= (abort_pending || last_ch) ? '0 : ch_sel + 1'b1;
      end
    end
  end

  assign ready     = (state == IDLE);
  assign latch_low = (state == LATCH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ship
    assign ship[i] = (state == SHIP) && (ch_sel == CH_W'(i));
  end

endmodule
`default_nettype wire

// File: tb/tb_ws2812_multi_frame_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ws2812_multi_frame_seq                                    |
// | Description : Directed self-checking bench for ws2812_multi_frame_seq with |
// |               NUM_CH=3, RESET_CYCLES=8, DEBOUNCE_CYCLES=4, FCNT_W=4.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_ws2812_multi_frame_seq;

  logic       clk = 1'b0;
  logic       reset, go, auto_mode, abort, bit_done;
  logic [2:0] ship;
  logic [1:0] ch_sel;
  logic       latch_low, ready, frame_done;
  logic [3:0] frame_count;

  int   n_checks = 0;
  int   n_pass   = 0;
  logic watch_100 = 1'b0;
  logic saw_100   = 1'b0;

  ws2812_multi_frame_seq #(
    .NUM_CH          (3),
    .RESET_CYCLES    (8),
    .DEBOUNCE_CYCLES (4),
    .FCNT_W          (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .go          (go),
    .auto_mode   (auto_mode),
    .abort       (abort),
    .bit_done    (bit_done),
    .ship        (ship),
    .ch_sel      (ch_sel),
    .latch_low   (latch_low),
    .ready       (ready),
    .frame_done  (frame_done),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (watch_100 && ship == 3'b100) saw_100 = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts consecutive sampled cycles with latch_low high (bounded).
  // mode 1 drops a stray bit_done, mode 2 raises abort, during the gap.
  task automatic count_latch(input int mode, output int n);
    n = 0;
    while (latch_low === 1'b1 && n < 20) begin
      n++;
      if (mode == 1 && n == 2) bit_done = 1'b1;
      if (mode == 2 && n == 3) abort = 1'b1;
      tick();
      bit_done = 1'b0;
      abort    = 1'b0;
    end
  endtask

  // Called on the first sampled SHIP cycle of a strip; bit_done 5 cycles later.
  task automatic do_strip(input logic [2:0] exp_ship, input logic [1:0] exp_ch, input int mode);
    int n;
    check("ship_on", ship, exp_ship);
    check("ch_sel", ch_sel, exp_ch);
    repeat (4) begin
      tick();
      check("ship_hold", ship, exp_ship);
    end
    bit_done = 1'b1;
    tick();
    bit_done = 1'b0;
    check("latch_start", latch_low, 1'b1);
    check("ship_off", ship, 3'b000);
    count_latch(mode, n);
    check("latch_len", n, 8);
  endtask

  initial begin
    int n;
    reset = 1'b1; go = 1'b0; auto_mode = 1'b0; abort = 1'b0; bit_done = 1'b0;
    repeat (2) tick();
    check("rst_ship", ship, 3'b000);
    check("rst_latch", latch_low, 1'b0);
    check("rst_ready", ready, 1'b1);
    check("rst_fdone", frame_done, 1'b0);
    check("rst_fcnt", frame_count, 4'd0);
    check("rst_chsel", ch_sel, 2'd0);
    reset = 1'b0;
    tick();
    check("idle_ready", ready, 1'b1);

    // spurious bit_done / abort in IDLE
    bit_done = 1'b1; abort = 1'b1;
    repeat (3) tick();
    bit_done = 1'b0; abort = 1'b0;
    check("spur_ready", ready, 1'b1);
    check("spur_ship", ship, 3'b000);
    check("spur_latch", latch_low, 1'b0);
    check("spur_fcnt", frame_count, 4'd0);

    // one-shot frame (stray bit_done during the second gap)
    go = 1'b1;
    tick();
    go = 1'b0;
    check("os_ready", ready, 1'b0);
    do_strip(3'b001, 2'd0, 0);
    do_strip(3'b010, 2'd1, 1);
    do_strip(3'b100, 2'd2, 0);
    check("os_fdone", frame_done, 1'b1);
    check("os_fcnt", frame_count, 4'd1);
    check("os_dbship", ship, 3'b000);
    check("os_dbready", ready, 1'b0);
    tick();
    check("os_fdone_pulse", frame_done, 1'b0);
    repeat (2) tick();
    check("os_db3", ready, 1'b0);
    tick();
    check("os_idle", ready, 1'b1);

    // debounce with a bouncing button
    go = 1'b1;
    tick();
    go = 1'b0;
    do_strip(3'b001, 2'd0, 0);
    do_strip(3'b010, 2'd1, 0);
    do_strip(3'b100, 2'd2, 0);
    check("db_fdone", frame_done, 1'b1);
    check("db_fcnt", frame_count, 4'd2);
    go = 1'b1;
    repeat (10) tick();
    check("db_held", ready, 1'b0);
    go = 1'b0;
    repeat (2) tick();
    go = 1'b1;
    tick();
    check("db_bounce", ready, 1'b0);
    go = 1'b0;
    repeat (3) tick();
    check("db_3after", ready, 1'b0);
    tick();
    check("db_4after", ready, 1'b1);

    // abort while ship=010
    watch_100 = 1'b1;
    go = 1'b1;
    tick();
    go = 1'b0;
    do_strip(3'b001, 2'd0, 0);
    check("ab_ship010", ship, 3'b010);
    repeat (2) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_latch", latch_low, 1'b1);
    check("ab_shipoff", ship, 3'b000);
    count_latch(0, n);
    check("ab_latch_len", n, 8);
    check("ab_ship", ship, 3'b000);
    check("ab_dbounce", ready, 1'b0);
    check("ab_fdone", frame_done, 1'b0);
    check("ab_fcnt", frame_count, 4'd2);
    repeat (3) tick();
    check("ab_db3", ready, 1'b0);
    tick();
    check("ab_idle", ready, 1'b1);

    // abort coincident with bit_done on the first strip
    go = 1'b1;
    tick();
    go = 1'b0;
    check("abc_ship", ship, 3'b001);
    abort = 1'b1; bit_done = 1'b1;
    tick();
    abort = 1'b0; bit_done = 1'b0;
    check("abc_latch", latch_low, 1'b1);
    count_latch(0, n);
    check("abc_latch_len", n, 8);
    check("abc_ship_after", ship, 3'b000);
    check("abc_dbounce", ready, 1'b0);
    check("abc_fdone", frame_done, 1'b0);
    repeat (4) tick();
    check("abc_idle", ready, 1'b1);
    check("abc_fcnt", frame_count, 4'd2);
    watch_100 = 1'b0;
    check("ab_no_ship100", saw_100, 1'b0);

    // abort during LATCH: gap kept, then DBOUNCE
    go = 1'b1;
    tick();
    go = 1'b0;
    do_strip(3'b001, 2'd0, 2);
    check("abl_ship", ship, 3'b000);
    check("abl_dbounce", ready, 1'b0);
    check("abl_fdone", frame_done, 1'b0);
    repeat (4) tick();
    check("abl_idle", ready, 1'b1);
    check("abl_fcnt", frame_count, 4'd2);

    // auto mode from reset: 17 back-to-back frames wrap the 4-bit count to 1
    reset = 1'b1; auto_mode = 1'b1;
    tick();
    check("au_rst_fcnt", frame_count, 4'd0);
    reset = 1'b0;
    tick();
    for (int f = 0; f < 17; f++) begin
      do_strip(3'b001, 2'd0, 0);
      do_strip(3'b010, 2'd1, 0);
      do_strip(3'b100, 2'd2, 0);
      check("au_fdone", frame_done, 1'b1);
      check("au_restart", ship, 3'b001);
      check("au_noidle", ready, 1'b0);
    end
    check("au_fcnt_wrap", frame_count, 4'd1);

    // asynchronous reset between edges in the middle of a latch gap
    repeat (4) tick();
    bit_done = 1'b1;
    tick();
    bit_done = 1'b0;
    check("ar_latch", latch_low, 1'b1);
    repeat (3) tick();
    #3;
    reset = 1'b1;
    #1;
    check("ar_latch_low", latch_low, 1'b0);
    check("ar_ship", ship, 3'b000);
    check("ar_ready", ready, 1'b1);
    check("ar_fcnt", frame_count, 4'd0);
    auto_mode = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("ar_idle", ready, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
